// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read adapter: reframes 18-bit words into a 16-bit SOF/EOF valid/ready stream.
// Optional statistics outputs are enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 18,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  output logic [15:0]           out_data,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_sof
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_drops
`endif
);

  typedef enum logic {HUNT, FRAME} state_t;

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  state_t      state, state_nxt;
  logic        inflight;
  logic [1:0]  occ, occ_nxt;
  logic [1:0]  credits;
  logic        push, pop, push_err, drop;
  logic        load_head, load_tail, tail_to_head;
  logic        w_sof, w_eof;
  logic [15:0] w_data;
  logic [15:0] t_data;
  logic        t_sof, t_eof, t_err;

  assign w_sof   = fifo_q[DATA_WIDTH-1];
  assign w_eof   = fifo_q[DATA_WIDTH-2];
  assign w_data  = fifo_q[15:0];
  assign out_valid = (occ != 2'd0);
  assign pop     = out_valid && out_ready;
  assign credits = occ + {1'b0, inflight};

  // A read may reuse the credit freed by a pop in the same cycle.
  assign fifo_rden = rst_n && !fifo_empty &&
                     ((credits < FULL) || (credits == FULL && pop));

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_err  = 1'b0;
    drop      = 1'b0;
    if (inflight) begin
      if (state == HUNT && !w_sof) begin
        drop = 1'b1;
      end else begin
        push      = 1'b1;
        push_err  = (state == FRAME) && w_sof;
        state_nxt = w_eof ? HUNT : FRAME;
      end
    end
  end

  always_comb begin
    load_head    = 1'b0;
    load_tail    = 1'b0;
    tail_to_head = 1'b0;
    occ_nxt      = occ;
    case ({push, pop})
      2'b10: begin
        if (occ == 2'd0) load_head = 1'b1;
        else             load_tail = 1'b1;
        occ_nxt = occ + 2'd1;
      end
      2'b01: begin
        if (occ == 2'd2) tail_to_head = 1'b1;
        occ_nxt = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          load_head = 1'b1;
        end else begin
          tail_to_head = 1'b1;
          load_tail    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      inflight <= 1'b0;
      occ      <= 2'd0;
      out_data <= 16'd0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
      err_sof  <= 1'b0;
      t_data   <= 16'd0;
      t_sof    <= 1'b0;
      t_eof    <= 1'b0;
      t_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rden;
      occ      <= occ_nxt;
      err_sof  <= 1'b0;
      // err_sof pulses when the offending word first appears at the head.
      if (load_head) begin
        out_data <= w_data;
        out_sof  <= w_sof;
        out_eof  <= w_eof;
        err_sof  <= push_err;
      end else if (tail_to_head) begin
        out_data <= t_data;
        out_sof  <= t_sof;
        out_eof  <= t_eof;
        err_sof  <= t_err;
      end
      if (load_tail) begin
        t_data <= w_data;
        t_sof  <= w_sof;
        t_eof  <= w_eof;
        t_err  <= push_err;
      end
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= 32'd0;
      stat_drops  <= 16'd0;
    end else begin
      if (pop && out_eof)
        stat_frames <= stat_frames + 32'd1;
      if (drop && stat_drops != 16'hFFFF)
        stat_drops <= stat_drops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream against a framing reference model.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [15:0] out_data;
  logic        out_sof, out_eof, out_valid, out_ready, err_sof;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] stat_frames;
  logic [15:0] stat_drops;
`endif

  fifo_rd_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rden  (fifo_rden),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_sof    (err_sof)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_drops (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  logic [17:0] src_q[$];
  logic [18:0] exp_q[$];
  logic        ref_in_frame;
  logic        rd_pending, stall_prev, cur_err;
  logic [18:0] held;
  int n_checks, n_fail;
  int cyc, rcnt, first_rden, first_valid, run, max_run, err_cnt;
  int tot_drops, tot_frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Framing rules: outside a frame only SOF words survive; a kept word ends the frame iff EOF.
  function automatic int ref_frame(input logic [17:0] w[$]);
    int drops = 0;
    foreach (w[i]) begin
      if (!ref_in_frame && !w[i][17]) begin
        drops++;
      end else begin
        exp_q.push_back({ref_in_frame && w[i][17], w[i][17], w[i][16], w[i][15:0]});
        ref_in_frame = !w[i][16];
      end
    end
    return drops;
  endfunction

  task automatic load(input logic [17:0] w[$]);
    foreach (w[i]) src_q.push_back(w[i]);
    tot_drops += ref_frame(w);
    first_rden = -1; first_valid = -1; max_run = 0; run = 0; err_cnt = 0; rcnt = 0;
  endtask

  task automatic step(input int rmode, input int gap_pct);
    logic [18:0] e;
    @(negedge clk);
    cyc++;
    if (rd_pending && src_q.size() > 0) fifo_q = src_q.pop_front();
    rd_pending = 1'b0;
    fifo_empty = (src_q.size() == 0) || (int'($urandom_range(0, 99)) < gap_pct);
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rcnt % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    rcnt++;
    #1;
    if (stall_prev) check("hold", {out_valid, out_sof, out_eof, out_data}, held);
    if (err_sof) begin
      err_cnt++;
      cur_err = 1'b1;
      check("err_with_valid", out_valid, 1);
    end
    if (fifo_rden) begin
      check("rden_while_empty", fifo_empty, 0);
      rd_pending = 1'b1;
      if (first_rden < 0) first_rden = cyc;
    end
    if (out_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (first_valid < 0) first_valid = cyc;
    end else begin
      run = 0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", out_valid && out_ready, 0);
      end else begin
        e = exp_q.pop_front();
        if (e[16]) tot_frames++;
        check("word", {cur_err, out_sof, out_eof, out_data}, e);
      end
      cur_err = 1'b0;
    end
    stall_prev = out_valid && !out_ready;
    held = {out_valid, out_sof, out_eof, out_data};
  endtask

  task automatic drain(input int rmode, input int gap_pct);
    int budget = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0 || rd_pending) && budget < 3000) begin
      step(rmode, gap_pct);
      budget++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (6) step(rmode, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] w[$];
    n_checks = 0; n_fail = 0; cyc = 0;
    tot_drops = 0; tot_frames = 0;
    ref_in_frame = 1'b0; rd_pending = 1'b0; stall_prev = 1'b0; cur_err = 1'b0; held = '0;
    fifo_q = 18'h0; fifo_empty = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_rden", fifo_rden, 0);
    check("rst_fields", {out_sof, out_eof, err_sof, out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame, always ready, latency
    w = '{18'h2_0001, 18'h0_0002, 18'h1_0003};
    load(w);
    drain(0, 0);
    check("latency", first_valid - first_rden, 2);
    check("single_run", max_run, 3);

    // Garbage before a frame
    w = '{18'h0_00AA, 18'h0_00BB, 18'h3_0055};
    load(w);
    drain(0, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("stat_drops", stat_drops, tot_drops);
`endif

    // Backpressure, 8-word frame
    w = '{};
    for (int i = 0; i < 8; i++)
      w.push_back({(i == 0), (i == 7), 16'h0100 + 16'(i)});
    load(w);
    drain(1, 0);

    // Nested SOF, then a non-SOF word that must be dropped in HUNT
    w = '{18'h2_0010, 18'h0_0011, 18'h2_0020, 18'h1_0021, 18'h0_0099};
    load(w);
    drain(2, 0);
    check("nested_err_cnt", err_cnt, 1);

    // Empty toggling mid-frame
    w = '{};
    for (int i = 0; i < 12; i++)
      w.push_back({(i == 0), (i == 11), 16'h0200 + 16'(i)});
    load(w);
    drain(0, 40);

    // Throughput
    w = '{};
    for (int i = 0; i < 64; i++)
      w.push_back({(i == 0), (i == 63), 16'h1000 + 16'(i)});
    load(w);
    drain(0, 0);
    check("throughput_run", max_run, 64);

    // Random words, random ready and FIFO gaps
    w = '{};
    for (int i = 0; i < 80; i++)
      w.push_back({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 16'($urandom)});
    load(w);
    drain(2, 25);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("stat_frames", stat_frames, tot_frames);
    check("stat_drops_rand", stat_drops, tot_drops);
`endif

    // Reset mid-frame: buffered/in-flight words lost, remaining frame tail dropped in HUNT
    w = '{};
    for (int i = 0; i < 10; i++)
      w.push_back({(i == 0), (i == 9), 16'h0300 + 16'(i)});
    load(w);
    repeat (6) step(1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_rden", fifo_rden, 0);
    if (rd_pending && src_q.size() > 0) void'(src_q.pop_front());
    rd_pending = 1'b0; stall_prev = 1'b0; cur_err = 1'b0;
    exp_q.delete();
    ref_in_frame = 1'b0;
    tot_drops = 0; tot_frames = 0;
    src_q.push_back(18'h3_0077);
    w = src_q;
    tot_drops += ref_frame(w);
    check("midrst_tail_dropped", exp_q.size(), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain(0, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("stat_drops_rst", stat_drops, tot_drops);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
